// File: rtl/traffic_pkg.sv
// Shared traffic-light definitions: light codes, lamp encodings and driver state.
// Imported by the traffic FSM and by the lamp safety driver.
package traffic_pkg;

    localparam logic [3:0] CODE_ALL_RED   = 4'd0;
    localparam logic [3:0] CODE_NS_GREEN  = 4'd1;
    localparam logic [3:0] CODE_NS_YELLOW = 4'd2;
    localparam logic [3:0] CODE_SN_GREEN  = 4'd3;
    localparam logic [3:0] CODE_SN_YELLOW = 4'd4;
    localparam logic [3:0] CODE_EW_GREEN  = 4'd5;
    localparam logic [3:0] CODE_EW_YELLOW = 4'd6;
    localparam logic [3:0] CODE_WE_GREEN  = 4'd7;
    localparam logic [3:0] CODE_WE_YELLOW = 4'd8;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    localparam int NUM_DIRS = 4;

    typedef enum logic [1:0] {DIR_NS, DIR_SN, DIR_EW, DIR_WE} dir_e;
    typedef enum logic [1:0] {DRV_DRIVE, DRV_CLEAR, DRV_FAULT} drv_state_e;

    // Indexed by dir_e: [0]=NS, [1]=SN, [2]=EW, [3]=WE.
    typedef logic [NUM_DIRS-1:0][2:0] lamp_vec_t;

    localparam lamp_vec_t LAMPS_ALL_RED = {NUM_DIRS{LAMP_RED}};
    localparam lamp_vec_t LAMPS_ALL_OFF = {NUM_DIRS{LAMP_OFF}};

    typedef struct packed {
        lamp_vec_t lamps;
        logic      illegal;
        logic      is_red;
        logic      is_green;
        logic      is_yellow;
        dir_e      dir;
    } code_info_t;

endpackage

// File: rtl/lamp_safety_driver_if.sv
// Link between the traffic FSM (master) and the lamp safety driver (slave).
interface lamp_safety_driver_if;
    logic [3:0] light_signal;
    logic [2:0] ns_lamp;
    logic [2:0] sn_lamp;
    logic [2:0] ew_lamp;
    logic [2:0] we_lamp;
    logic       clear_active;
    logic       fault;

    modport master (
        output light_signal,
        input  ns_lamp, sn_lamp, ew_lamp, we_lamp, clear_active, fault
    );

    modport slave (
        input  light_signal,
        output ns_lamp, sn_lamp, ew_lamp, we_lamp, clear_active, fault
    );
endinterface

// File: rtl/light_code_decoder.sv
// Combinational decode of a 4-bit light code into lamp vectors and class fields.
module light_code_decoder
    import traffic_pkg::*;
(
    input  logic [3:0] i_code,
    output code_info_t o_info
);

    dir_e w_dir;
    logic w_grn;
    logic w_yel;

    always_comb begin
        w_dir = DIR_NS;
        w_grn = 1'b0;
        w_yel = 1'b0;
        case (i_code)
            CODE_NS_GREEN:  begin w_dir = DIR_NS; w_grn = 1'b1; end
            CODE_NS_YELLOW: begin w_dir = DIR_NS; w_yel = 1'b1; end
            CODE_SN_GREEN:  begin w_dir = DIR_SN; w_grn = 1'b1; end
            CODE_SN_YELLOW: begin w_dir = DIR_SN; w_yel = 1'b1; end
            CODE_EW_GREEN:  begin w_dir = DIR_EW; w_grn = 1'b1; end
            CODE_EW_YELLOW: begin w_dir = DIR_EW; w_yel = 1'b1; end
            CODE_WE_GREEN:  begin w_dir = DIR_WE; w_grn = 1'b1; end
            CODE_WE_YELLOW: begin w_dir = DIR_WE; w_yel = 1'b1; end
            default: ;
        endcase
    end

    // Illegal codes decode to all-red so a stray decode can never light a head.
    always_comb begin
        o_info.lamps = LAMPS_ALL_RED;
        if (w_grn)
            o_info.lamps[w_dir] = LAMP_GRN;
        else if (w_yel)
            o_info.lamps[w_dir] = LAMP_YEL;
        o_info.illegal   = (i_code > CODE_WE_YELLOW);
        o_info.is_red    = (i_code == CODE_ALL_RED);
        o_info.is_green  = w_grn;
        o_info.is_yellow = w_yel;
        o_info.dir       = w_dir;
    end

endmodule

// File: rtl/lamp_safety_driver.sv
// Lamp head driver behind the traffic FSM: enforces yellow->green all-red clearance,
// traps illegal codes/sequences into a latched flashing-red fault, registers all lamps.
module lamp_safety_driver
    import traffic_pkg::*;
#(
    parameter int CLEAR_CYCLES = 2,
    parameter int FLASH_HALF   = 4,
    parameter int FAULT_EXIT   = 3,
    parameter int CNT_W        = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    lamp_safety_driver_if.slave  bus
);

    localparam logic [CNT_W-1:0] CLR_LOAD   = CNT_W'(CLEAR_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLASH_LOAD = CNT_W'(FLASH_HALF - 1);
    localparam logic [CNT_W-1:0] EXIT_LAST  = CNT_W'(FAULT_EXIT - 1);

    code_info_t w_in;

    light_code_decoder u_dec (
        .i_code (bus.light_signal),
        .o_info (w_in)
    );

    drv_state_e       r_state;
    logic [3:0]       r_disp;
    logic             r_disp_grn;
    logic             r_disp_yel;
    dir_e             r_disp_dir;
    logic [3:0]       r_tgt;
    lamp_vec_t        r_tgt_lamps;
    dir_e             r_tgt_dir;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_exit_cnt;
    lamp_vec_t        r_lamps;
    logic             r_clear;
    logic             r_fault;

    logic w_change;
    logic w_seq_bad;

    // A showing green may only step to its own yellow; anything else is a skipped yellow.
    assign w_change  = (bus.light_signal != r_disp);
    assign w_seq_bad = r_disp_grn && !(w_in.is_yellow && (w_in.dir == r_disp_dir));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= DRV_DRIVE;
            r_disp      <= CODE_ALL_RED;
            r_disp_grn  <= 1'b0;
            r_disp_yel  <= 1'b0;
            r_disp_dir  <= DIR_NS;
            r_tgt       <= CODE_ALL_RED;
            r_tgt_lamps <= LAMPS_ALL_RED;
            r_tgt_dir   <= DIR_NS;
            r_cnt       <= '0;
            r_exit_cnt  <= '0;
            r_lamps     <= LAMPS_ALL_RED;
            r_clear     <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            case (r_state)
                DRV_DRIVE: begin
                    if (w_change) begin
                        if (w_in.illegal || w_seq_bad) begin
                            r_state    <= DRV_FAULT;
                            r_fault    <= 1'b1;
                            r_clear    <= 1'b0;
                            r_lamps    <= LAMPS_ALL_RED;
                            r_cnt      <= FLASH_LOAD;
                            r_exit_cnt <= '0;
                        end else if (r_disp_yel && w_in.is_green) begin
                            r_state     <= DRV_CLEAR;
                            r_tgt       <= bus.light_signal;
                            r_tgt_lamps <= w_in.lamps;
                            r_tgt_dir   <= w_in.dir;
                            r_disp      <= CODE_ALL_RED;
                            r_disp_grn  <= 1'b0;
                            r_disp_yel  <= 1'b0;
                            r_cnt       <= CLR_LOAD;
                            r_lamps     <= LAMPS_ALL_RED;
                            r_clear     <= 1'b1;
                        end else begin
                            r_disp     <= bus.light_signal;
                            r_disp_grn <= w_in.is_green;
                            r_disp_yel <= w_in.is_yellow;
                            r_disp_dir <= w_in.dir;
                            r_lamps    <= w_in.lamps;
                        end
                    end
                end

                // Legal input changes are ignored here; an illegal code aborts the target.
                DRV_CLEAR: begin
                    if (w_in.illegal) begin
                        r_state    <= DRV_FAULT;
                        r_fault    <= 1'b1;
                        r_clear    <= 1'b0;
                        r_lamps    <= LAMPS_ALL_RED;
                        r_cnt      <= FLASH_LOAD;
                        r_exit_cnt <= '0;
                    end else if (r_cnt == '0) begin
                        r_state    <= DRV_DRIVE;
                        r_disp     <= r_tgt;
                        r_disp_grn <= 1'b1;
                        r_disp_yel <= 1'b0;
                        r_disp_dir <= r_tgt_dir;
                        r_lamps    <= r_tgt_lamps;
                        r_clear    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                DRV_FAULT: begin
                    if (r_cnt == '0) begin
                        r_cnt   <= FLASH_LOAD;
                        r_lamps <= (r_lamps[DIR_NS] == LAMP_RED) ? LAMPS_ALL_OFF : LAMPS_ALL_RED;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                    if (w_in.is_red) begin
                        if (r_exit_cnt == EXIT_LAST) begin
                            r_state    <= DRV_DRIVE;
                            r_disp     <= CODE_ALL_RED;
                            r_disp_grn <= 1'b0;
                            r_disp_yel <= 1'b0;
                            r_lamps    <= LAMPS_ALL_RED;
                            r_fault    <= 1'b0;
                            r_cnt      <= '0;
                            r_exit_cnt <= '0;
                        end else begin
                            r_exit_cnt <= r_exit_cnt + 1'b1;
                        end
                    end else begin
                        r_exit_cnt <= '0;
                    end
                end

                default: r_state <= DRV_DRIVE;
            endcase
        end
    end

    assign bus.ns_lamp      = r_lamps[DIR_NS];
    assign bus.sn_lamp      = r_lamps[DIR_SN];
    assign bus.ew_lamp      = r_lamps[DIR_EW];
    assign bus.we_lamp      = r_lamps[DIR_WE];
    assign bus.clear_active = r_clear;
    assign bus.fault        = r_fault;

    logic [NUM_DIRS-1:0] w_grn_on;
    logic [NUM_DIRS-1:0] w_yel_on;
    logic [NUM_DIRS-1:0] w_hot;

    always_comb begin
        for (int d = 0; d < NUM_DIRS; d++) begin
            w_grn_on[d] = (r_lamps[d] == LAMP_GRN);
            w_yel_on[d] = (r_lamps[d] == LAMP_YEL);
            w_hot[d]    = $onehot(r_lamps[d]);
        end
    end

    a_one_dir_lit: assert property (@(posedge clk) disable iff (rst)
        $onehot0(w_grn_on | w_yel_on));
    a_lamp_onehot: assert property (@(posedge clk) disable iff (rst)
        !r_fault |-> (&w_hot));
    a_no_yel_to_grn: assert property (@(posedge clk) disable iff (rst)
        (|w_yel_on) |=> !(|w_grn_on));

endmodule

// File: tb/tb_lamp_safety_driver.sv
// Directed plus randomized checks of lamp_safety_driver against a code-level reference model.
module tb_lamp_safety_driver;

    localparam int CLEAR_CYCLES = 2;
    localparam int FLASH_HALF   = 4;
    localparam int FAULT_EXIT   = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lamp_safety_driver_if bus();

    lamp_safety_driver #(
        .CLEAR_CYCLES (CLEAR_CYCLES),
        .FLASH_HALF   (FLASH_HALF),
        .FAULT_EXIT   (FAULT_EXIT),
        .CNT_W        (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: mode 0 = normal, 1 = clearance, 2 = fault.
    int m_mode, m_disp, m_tgt, m_clr_left, m_age, m_zero;
    logic prev_yel = 1'b0;

    task automatic model_reset();
        m_mode = 0; m_disp = 0; m_tgt = 0; m_clr_left = 0; m_age = 0; m_zero = 0;
        prev_yel = 1'b0;
    endtask

    task automatic model_fault();
        m_mode = 2; m_age = 0; m_zero = 0;
    endtask

    task automatic model_edge(input int c);
        bit legal;
        legal = (c <= 8);
        case (m_mode)
            0: if (c != m_disp) begin
                if (!legal) model_fault();
                else if (m_disp == 0) m_disp = c;
                else if (m_disp % 2 == 1) begin
                    if (c == m_disp + 1) m_disp = c;
                    else model_fault();
                end else if (c % 2 == 1) begin
                    m_tgt = c; m_disp = 0; m_mode = 1; m_clr_left = CLEAR_CYCLES;
                end else m_disp = c;
            end
            1: if (!legal) model_fault();
               else begin
                   m_clr_left--;
                   if (m_clr_left == 0) begin m_mode = 0; m_disp = m_tgt; end
               end
            default: begin
                m_age++;
                m_zero = (c == 0) ? m_zero + 1 : 0;
                if (m_zero == FAULT_EXIT) begin m_mode = 0; m_disp = 0; end
            end
        endcase
    endtask

    function automatic logic [2:0] lamp_of(input int code, input int d);
        if (code == 0 || code > 8) return 3'b100;
        if ((code - 1) / 2 != d) return 3'b100;
        return (code % 2 == 1) ? 3'b001 : 3'b010;
    endfunction

    function automatic logic [13:0] model_out();
        logic [2:0] l [4];
        for (int d = 0; d < 4; d++) begin
            if (m_mode == 0) l[d] = lamp_of(m_disp, d);
            else if (m_mode == 1) l[d] = 3'b100;
            else l[d] = ((m_age / FLASH_HALF) % 2 == 0) ? 3'b100 : 3'b000;
        end
        return {l[0], l[1], l[2], l[3], m_mode == 1, m_mode == 2};
    endfunction

    task automatic check(input string tag);
        logic [13:0] got, exp;
        logic cur_yel, cur_grn;
        got = {bus.ns_lamp, bus.sn_lamp, bus.ew_lamp, bus.we_lamp, bus.clear_active, bus.fault};
        exp = model_out();
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
        cur_yel = 1'b0; cur_grn = 1'b0;
        for (int d = 0; d < 4; d++) begin
            cur_yel |= (got[13 - 3*d -: 3] == 3'b010);
            cur_grn |= (got[13 - 3*d -: 3] == 3'b001);
        end
        total++;
        assert (!(prev_yel && cur_grn)) else begin
            bad++;
            $error("FAIL %s_yel_to_grn got=%b exp=no_green_after_yellow", tag, got);
        end
        prev_yel = cur_yel;
    endtask

    task automatic step(input logic [3:0] c, input string tag);
        bus.light_signal = c;
        @(posedge clk);
        model_edge(int'(c));
        #1;
        check(tag);
    endtask

    logic [3:0] cur;
    int r, pick;

    initial begin
        rst = 1'b1;
        bus.light_signal = 4'd0;
        model_reset();
        #12;
        check("reset");
        @(negedge clk);
        rst = 1'b0;

        step(4'd0, "idle");
        step(4'd1, "ns_green");
        step(4'd2, "ns_yellow");
        step(4'd0, "ns_red");

        step(4'd2, "yel_again");
        step(4'd3, "clear1");
        step(4'd3, "clear2");
        step(4'd3, "sn_green");

        step(4'd5, "g2g_fault");
        for (int i = 0; i < 9; i++) step(4'd5, "flash");
        step(4'd0, "exit_z1");
        step(4'd0, "exit_z2");
        step(4'd0, "exit_z3");
        step(4'd0, "solid_red");

        step(4'd2, "pre_clr_yel");
        step(4'd3, "clr_enter");
        step(4'd10, "clr_illegal");
        step(4'd0, "fz1");
        step(4'd0, "fz2");
        step(4'd1, "fz_break");
        step(4'd0, "fz3");
        step(4'd0, "fz4");
        step(4'd0, "fz5_exit");

        cur = 4'd0;
        for (int n = 0; n < 500; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 8) cur = 4'($urandom_range(0, 15));
            else if (r < 35) cur = cur;
            else if (m_mode == 2) cur = (r < 85) ? 4'd0 : 4'($urandom_range(1, 8));
            else if (cur == 4'd0 || cur > 4'd8) cur = 4'($urandom_range(0, 8));
            else if (cur[0]) cur = (r < 85) ? cur + 4'd1 : 4'($urandom_range(0, 8));
            else begin
                pick = int'($urandom_range(0, 3));
                if (r < 65) cur = 4'(2 * pick + 1);
                else if (r < 85) cur = 4'd0;
                else cur = 4'(2 * pick + 2);
            end
            step(cur, "random");
        end

        step(4'd0, "pre_rst_idle");
        step(4'd2, "pre_rst_yel");
        step(4'd7, "pre_rst_clr");
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check("async_rst");
        #2;
        rst = 1'b0;
        step(4'd0, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
